card_pair_checker: RTL and testbench

- Game-logic reader of the card regfile. The colour-init block fills regfile addresses 1..12 with 14-bit card entries; this block reads two selected entries back, compares their colours, and writes the updated status back to the regfile.
- Entry format: bit0 = active, bit1 = discovered, bits[13:2] = colour (r,g,b, MSB first). Address 0 is reserved and never touched.
- Sits between the player-input/selection logic and the regfile write port; it also keeps the matched-pair score.

---
 rtl/card_pair_checker.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_card_pair_checker.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_pair_checker.sv
// card_pair_checker: game-logic reader of the card regfile.
// Reads two selected card entries, compares their colours, writes the
// updated status back and keeps the matched-pair score.
// Entry format: bit0 = active, bit1 = discovered, bits[13:2] = colour.
// Optional build macro MISMATCH_HOLD_EN: a mismatched pair is first written
// back as shown (2'b11), held for HOLD_CYCLES cycles, then covered again.
module card_pair_checker #(
  parameter int NUM_CARDS   = 12,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  card_a,
  input  logic [3:0]  card_b,
  input  logic        clear_score,
  output logic [3:0]  rd_address,
  input  logic [13:0] rd_data,
  output logic        wr_en,
  output logic [3:0]  wr_address,
  output logic [13:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        invalid,
  output logic [3:0]  matched_pairs,
  output logic        all_cleared
);

  localparam logic [3:0] MAX_ADDR  = 4'(NUM_CARDS);
  localparam logic [3:0] MAX_PAIRS = 4'(NUM_CARDS / 2);

  // Status flag pairs {discovered, active} written back with the colour
  localparam logic [1:0] FLAGS_DISCOVERED = 2'b10;
  localparam logic [1:0] FLAGS_COVERED    = 2'b01;

`ifdef MISMATCH_HOLD_EN
  localparam logic [1:0] FLAGS_SHOWN          = 2'b11;
  localparam logic [1:0] FLAGS_MISMATCH_FIRST = FLAGS_SHOWN;
  localparam int         HOLD_W               = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST     = HOLD_W'(HOLD_CYCLES - 1);
`else
  localparam logic [1:0] FLAGS_MISMATCH_FIRST = FLAGS_COVERED;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CMP,
    S_WR_A,
    S_WR_B,
`ifdef MISMATCH_HOLD_EN
    S_HOLD,
    S_WR_A2,
    S_WR_B2,
`endif
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  card_a_q, card_a_d;
  logic [3:0]  card_b_q, card_b_d;
  logic [13:0] entry_a_q, entry_a_d;
  logic [13:0] entry_b_q, entry_b_d;
  logic        is_match_q, is_match_d;
  logic [3:0]  rd_address_q, rd_address_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_address_q, wr_address_d;
  logic [13:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        match_q, match_d;
  logic        invalid_q, invalid_d;
  logic [3:0]  matched_pairs_q, matched_pairs_d;
`ifdef MISMATCH_HOLD_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  logic sel_invalid;
  logic colour_equal;
  logic [3:0] pairs_inc;
  logic unused_flags;

  // Rejection test during CMP: entry_b is still on rd_data this cycle
  assign sel_invalid = (card_a_q == card_b_q) ||
                       (card_a_q == 4'd0) || (card_a_q > MAX_ADDR) ||
                       (card_b_q == 4'd0) || (card_b_q > MAX_ADDR) ||
                       !entry_a_q[0] || !rd_data[0];

  assign colour_equal = (entry_a_q[13:2] == rd_data[13:2]);

  // Score saturates once every pair has been found
  assign pairs_inc = (matched_pairs_q == MAX_PAIRS) ? matched_pairs_q
                                                    : matched_pairs_q + 4'd1;

  // Discovered bits of the read entries play no part in the check
  assign unused_flags = ^{entry_a_q[1], entry_b_q[1:0]};

  // Next-state and next-output logic; every output is registered
  always_comb begin
    state_d         = state_q;
    card_a_d        = card_a_q;
    card_b_d        = card_b_q;
    entry_a_d       = entry_a_q;
    entry_b_d       = entry_b_q;
    is_match_d      = is_match_q;
    rd_address_d    = 4'd0;
    wr_en_d         = 1'b0;
    wr_address_d    = 4'd0;
    wr_data_d       = 14'd0;
    done_d          = 1'b0;
    match_d         = match_q;
    invalid_d       = invalid_q;
    matched_pairs_d = matched_pairs_q;
`ifdef MISMATCH_HOLD_EN
    hold_cnt_d      = hold_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (clear_score) begin
          matched_pairs_d = 4'd0;
        end
        if (start) begin
          card_a_d     = card_a;
          card_b_d     = card_b;
          rd_address_d = card_a;
          state_d      = S_RD_A;
        end
      end

      S_RD_A: begin
        rd_address_d = card_b_q;
        state_d      = S_RD_B;
      end

      S_RD_B: begin
        entry_a_d = rd_data;
        state_d   = S_CMP;
      end

      S_CMP: begin
        entry_b_d = rd_data;
        if (sel_invalid) begin
          is_match_d = 1'b0;
          match_d    = 1'b0;
          invalid_d  = 1'b1;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end else begin
          is_match_d   = colour_equal;
          wr_en_d      = 1'b1;
          wr_address_d = card_a_q;
          wr_data_d    = {entry_a_q[13:2],
                          colour_equal ? FLAGS_DISCOVERED : FLAGS_MISMATCH_FIRST};
          state_d      = S_WR_A;
        end
      end

      S_WR_A: begin
        wr_en_d      = 1'b1;
        wr_address_d = card_b_q;
        wr_data_d    = {entry_b_q[13:2],
                        is_match_q ? FLAGS_DISCOVERED : FLAGS_MISMATCH_FIRST};
        state_d      = S_WR_B;
      end

      S_WR_B: begin
        if (is_match_q) begin
          matched_pairs_d = pairs_inc;
        end
`ifdef MISMATCH_HOLD_EN
        if (is_match_q) begin
          match_d   = 1'b1;
          invalid_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          hold_cnt_d = '0;
          state_d    = S_HOLD;
        end
`else
        match_d   = is_match_q;
        invalid_d = 1'b0;
        done_d    = 1'b1;
        state_d   = S_DONE;
`endif
      end

`ifdef MISMATCH_HOLD_EN
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          wr_en_d      = 1'b1;
          wr_address_d = card_a_q;
          wr_data_d    = {entry_a_q[13:2], FLAGS_COVERED};
          state_d      = S_WR_A2;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      S_WR_A2: begin
        wr_en_d      = 1'b1;
        wr_address_d = card_b_q;
        wr_data_d    = {entry_b_q[13:2], FLAGS_COVERED};
        state_d      = S_WR_B2;
      end

      S_WR_B2: begin
        match_d   = 1'b0;
        invalid_d = 1'b0;
        done_d    = 1'b1;
        state_d   = S_DONE;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      card_a_q        <= 4'd0;
      card_b_q        <= 4'd0;
      entry_a_q       <= 14'd0;
      entry_b_q       <= 14'd0;
      is_match_q      <= 1'b0;
      rd_address_q    <= 4'd0;
      wr_en_q         <= 1'b0;
      wr_address_q    <= 4'd0;
      wr_data_q       <= 14'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      match_q         <= 1'b0;
      invalid_q       <= 1'b0;
      matched_pairs_q <= 4'd0;
`ifdef MISMATCH_HOLD_EN
      hold_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      card_a_q        <= card_a_d;
      card_b_q        <= card_b_d;
      entry_a_q       <= entry_a_d;
      entry_b_q       <= entry_b_d;
      is_match_q      <= is_match_d;
      rd_address_q    <= rd_address_d;
      wr_en_q         <= wr_en_d;
      wr_address_q    <= wr_address_d;
      wr_data_q       <= wr_data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      match_q         <= match_d;
      invalid_q       <= invalid_d;
      matched_pairs_q <= matched_pairs_d;
`ifdef MISMATCH_HOLD_EN
      hold_cnt_q      <= hold_cnt_d;
`endif
    end
  end

  assign rd_address    = rd_address_q;
  assign wr_en         = wr_en_q;
  assign wr_address    = wr_address_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign match         = match_q;
  assign invalid       = invalid_q;
  assign matched_pairs = matched_pairs_q;
  assign all_cleared   = (matched_pairs_q == MAX_PAIRS);

endmodule

// File: tb/tb_card_pair_checker.sv
// tb_card_pair_checker: scoreboard bench for card_pair_checker with a
// behavioural regfile and a card-game reference model.
module tb_card_pair_checker;

  localparam int NUM_CARDS  = 12;
  localparam int HOLD       = 4;
  localparam int WAIT_LIMIT = 40 + HOLD;
`ifdef MISMATCH_HOLD_EN
  localparam int MISS_LAT   = 8 + HOLD;
  localparam bit HOLD_BUILD = 1'b1;
`else
  localparam int MISS_LAT   = 6;
  localparam bit HOLD_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  card_a = 4'd0;
  logic [3:0]  card_b = 4'd0;
  logic        clear_score = 1'b0;
  logic [3:0]  rd_address;
  logic [13:0] rd_data;
  logic        wr_en;
  logic [3:0]  wr_address;
  logic [13:0] wr_data;
  logic        busy;
  logic        done;
  logic        match;
  logic        invalid;
  logic [3:0]  matched_pairs;
  logic        all_cleared;

  card_pair_checker #(
    .NUM_CARDS   (NUM_CARDS),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .card_a        (card_a),
    .card_b        (card_b),
    .clear_score   (clear_score),
    .rd_address    (rd_address),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_address    (wr_address),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .match         (match),
    .invalid       (invalid),
    .matched_pairs (matched_pairs),
    .all_cleared   (all_cleared)
  );

  // Free-running clock and cycle counter used for latency measurement
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Card i and card i+6 share a colour
  function automatic logic [11:0] colour_of(input int card);
    case ((card - 1) % 6)
      0: colour_of = 12'hF00;
      1: colour_of = 12'h0F0;
      2: colour_of = 12'h00F;
      3: colour_of = 12'hFF0;
      4: colour_of = 12'h0FF;
      default: colour_of = 12'hF0F;
    endcase
  endfunction

  // Behavioural regfile: registered read, write on wr_en, bulk re-init
  logic [13:0] regmem [16];
  logic        reinit_req = 1'b0;

  always @(posedge clk) begin
    if (reinit_req) begin
      for (int i = 0; i < 16; i++)
        regmem[i] <= (i >= 1 && i <= NUM_CARDS) ? {colour_of(i), 2'b01} : 14'd0;
    end else if (wr_en) begin
      regmem[wr_address] <= wr_data;
    end
    rd_data <= regmem[rd_address];
  end

  // Reference model of the game board and score
  logic [11:0] ref_col [16];
  bit          ref_act [16];
  int          ref_pairs = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [13:0] data;
  } wr_t;

  typedef struct packed {
    bit match;
    bit invalid;
    int pairs;
    int lat;
    int start_cyc;
  } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  wr_t  mon_w;
  res_t mon_r;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic ref_reinit();
    for (int i = 0; i < 16; i++) begin
      ref_act[i] = (i >= 1 && i <= NUM_CARDS);
      ref_col[i] = ref_act[i] ? colour_of(i) : 12'd0;
    end
  endtask

  task automatic reinit_regfile();
    @(negedge clk);
    reinit_req = 1'b1;
    @(negedge clk);
    reinit_req = 1'b0;
    ref_reinit();
  endtask

  // Game rules: derive the expected writes and result of one check
  task automatic model_check(input logic [3:0] a, input logic [3:0] b,
                             input logic clr, input int c0);
    res_t r;
    int   ia, ib;
    bit   rej;
    ia = int'(a);
    ib = int'(b);
    if (clr) ref_pairs = 0;
    rej = (ia == ib) || ia == 0 || ia > NUM_CARDS || ib == 0 || ib > NUM_CARDS;
    if (!rej) rej = !ref_act[ia] || !ref_act[ib];
    r.start_cyc = c0;
    r.invalid   = rej;
    r.match     = 1'b0;
    if (rej) begin
      r.lat = 4;
    end else if (ref_col[ia] == ref_col[ib]) begin
      r.match = 1'b1;
      r.lat   = 6;
      exp_wr.push_back({a, ref_col[ia], 2'b10});
      exp_wr.push_back({b, ref_col[ib], 2'b10});
      ref_act[ia] = 1'b0;
      ref_act[ib] = 1'b0;
      if (ref_pairs < NUM_CARDS / 2) ref_pairs++;
    end else begin
      r.lat = MISS_LAT;
      if (HOLD_BUILD) begin
        exp_wr.push_back({a, ref_col[ia], 2'b11});
        exp_wr.push_back({b, ref_col[ib], 2'b11});
      end
      exp_wr.push_back({a, ref_col[ia], 2'b01});
      exp_wr.push_back({b, ref_col[ib], 2'b01});
    end
    r.pairs = ref_pairs;
    exp_res.push_back(r);
  endtask

  // Monitor: pop and compare each write and each completed check
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          check_output("unexpected_wr_en", 32'(wr_en), 32'd0);
        end else begin
          mon_w = exp_wr.pop_front();
          check_output("wr_address", 32'(wr_address), 32'(mon_w.addr));
          check_output("wr_data", 32'(wr_data), 32'(mon_w.data));
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          check_output("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_r = exp_res.pop_front();
          check_output("match", 32'(match), 32'(mon_r.match));
          check_output("invalid", 32'(invalid), 32'(mon_r.invalid));
          check_output("matched_pairs", 32'(matched_pairs), 32'(mon_r.pairs));
          check_output("all_cleared", 32'(all_cleared), 32'(mon_r.pairs == NUM_CARDS / 2));
          check_output("latency", 32'(cyc - mon_r.start_cyc), 32'(mon_r.lat));
          check_output("busy_in_done", 32'(busy), 32'd1);
          check_output("missing_writes", 32'(exp_wr.size()), 32'd0);
        end
        done_seen++;
      end
    end
  end

  // One pair check; optionally pokes start again while the DUT is in RD_B
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b,
                                input logic clr, input bit poke);
    int c0, prev, k;
    @(negedge clk);
    c0   = cyc;
    prev = done_seen;
    model_check(a, b, clr, c0);
    card_a      = a;
    card_b      = b;
    clear_score = clr;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    clear_score = 1'b0;
    check_output("rd_address_a", 32'(rd_address), 32'(a));
    @(negedge clk);
    check_output("rd_address_b", 32'(rd_address), 32'(b));
    if (poke) begin
      card_a = 4'd1;
      card_b = 4'd7;
      start  = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    k = 0;
    while (done_seen == prev && k < WAIT_LIMIT) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_output("done_count", 32'(done_seen - prev), 32'd1);
    if (done_seen == prev) begin
      exp_wr.delete();
      exp_res.delete();
    end
    @(negedge clk);
    #1;
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("idle_rd_address", 32'(rd_address), 32'd0);
    if (poke) begin
      repeat (10) @(negedge clk);
      #1;
      check_output("single_done", 32'(done_seen - prev), 32'd1);
    end
  endtask

  task automatic apply_clear();
    @(negedge clk);
    clear_score = 1'b1;
    ref_pairs   = 0;
    @(negedge clk);
    clear_score = 1'b0;
    #1;
    check_output("cleared_pairs", 32'(matched_pairs), 32'd0);
    check_output("cleared_all", 32'(all_cleared), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check_output("rst_rd_address", 32'(rd_address), 32'd0);
    check_output("rst_wr_en", 32'(wr_en), 32'd0);
    check_output("rst_wr_address", 32'(wr_address), 32'd0);
    check_output("rst_wr_data", 32'(wr_data), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_match", 32'(match), 32'd0);
    check_output("rst_invalid", 32'(invalid), 32'd0);
    check_output("rst_matched_pairs", 32'(matched_pairs), 32'd0);
    check_output("rst_all_cleared", 32'(all_cleared), 32'd0);
  endtask

  // Start a matching check, then pull reset while the first write is shown
  task automatic reset_mid_check(input logic [3:0] a, input logic [3:0] b);
    int k;
    @(negedge clk);
    model_check(a, b, 1'b0, cyc);
    card_a = a;
    card_b = b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!wr_en && k < WAIT_LIMIT) begin
      @(negedge clk);
      k++;
    end
    check_output("reached_wr_a", 32'(wr_en), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    exp_wr.delete();
    exp_res.delete();
    ref_pairs = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("post_reset_busy", 32'(busy), 32'd0);
    check_output("post_reset_rd_address", 32'(rd_address), 32'd0);
  endtask

  // Main sequence: reset, directed game scenarios, random play, mid-check reset
  initial begin
    logic [3:0] ra, rb;
    logic       rc;
    $display("[TB] card_pair_checker bench start");
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    reinit_regfile();
    ref_pairs = 0;

    apply_stimulus(4'd1, 4'd7, 1'b0, 1'b0);
    apply_stimulus(4'd2, 4'd3, 1'b0, 1'b0);
    apply_stimulus(4'd5, 4'd5, 1'b0, 1'b0);
    apply_stimulus(4'd0, 4'd3, 1'b0, 1'b0);
    apply_stimulus(4'd13, 4'd1, 1'b0, 1'b0);
    apply_stimulus(4'd1, 4'd7, 1'b0, 1'b0);

    apply_stimulus(4'd2, 4'd8, 1'b0, 1'b1);
    for (int p = 3; p <= 6; p++)
      apply_stimulus(4'(p), 4'(p + 6), 1'b0, 1'b0);
    apply_stimulus(4'd1, 4'd7, 1'b0, 1'b0);

    reinit_regfile();
    apply_stimulus(4'd4, 4'd10, 1'b0, 1'b0);
    apply_clear();

    reinit_regfile();
    for (int n = 0; n < 40; n++) begin
      ra = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1 && ra >= 4'd1 && ra <= 4'd12)
        rb = (ra <= 4'd6) ? ra + 4'd6 : ra - 4'd6;
      else
        rb = 4'($urandom_range(0, 15));
      rc = ($urandom_range(0, 9) == 0);
      apply_stimulus(ra, rb, rc, 1'b0);
    end

    reinit_regfile();
    apply_stimulus(4'd1, 4'd7, 1'b0, 1'b0);
    reset_mid_check(4'd2, 4'd8);
    reinit_regfile();
    apply_stimulus(4'd3, 4'd9, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence itself stalls
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected summary (total=%0d bad=%0d)", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
